// File: rtl/load_store_unit.sv
// Memory-access stage: single-outstanding req/gnt/rvalid data-memory transaction with lane steering.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned accesses fault instead of being force-aligned.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [63:0] ex_addr,
  input  logic [63:0] ex_wdata,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [63:0] lsu_rdata,
  output logic        lsu_fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wstrb,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [63:0] dmem_rdata
);

  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_load;
  logic [2:0]    f3;
  logic [2:0]    off;

  logic          start;
  logic          tmo;
  logic [2:0]    align_mask;
  logic [2:0]    off_al;
  logic [7:0]    strb_base;
  logic [63:0]   st_wdata;
  logic [7:0]    st_strb;
  logic [63:0]   raw;
  logic [63:0]   ld_ext;

  assign start = ex_valid & (ex_load | ex_store);
  assign tmo   = (cnt == CW'(TIMEOUT - 1));

  // Size-derived alignment mask and byte-enable pattern for the incoming access
  always_comb begin
    align_mask = 3'b111;
    strb_base  = 8'h01;
    case (ex_funct3[1:0])
      2'b00: begin align_mask = 3'b111; strb_base = 8'h01; end
      2'b01: begin align_mask = 3'b110; strb_base = 8'h03; end
      2'b10: begin align_mask = 3'b100; strb_base = 8'h0F; end
      default: begin align_mask = 3'b000; strb_base = 8'hFF; end
    endcase
  end

  assign off_al   = ex_addr[2:0] & align_mask;
  assign st_wdata = ex_wdata << {off_al, 3'b000};
  assign st_strb  = strb_base << off_al;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misal;
  assign misal = |(ex_addr[2:0] & ~align_mask);
`endif

  // Right-align the addressed lanes and extend per the latched funct3
  assign raw = dmem_rdata >> {off, 3'b000};
  always_comb begin
    ld_ext = raw;
    case (f3)
      3'b000: ld_ext = {{56{raw[7]}}, raw[7:0]};
      3'b001: ld_ext = {{48{raw[15]}}, raw[15:0]};
      3'b010: ld_ext = {{32{raw[31]}}, raw[31:0]};
      3'b100: ld_ext = {56'd0, raw[7:0]};
      3'b101: ld_ext = {48'd0, raw[15:0]};
      3'b110: ld_ext = {32'd0, raw[31:0]};
      default: ld_ext = raw;
    endcase
  end

  assign lsu_stall = ((state == IDLE) & start) | (state == REQ) | (state == WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      is_load    <= 1'b0;
      f3         <= 3'd0;
      off        <= 3'd0;
      lsu_done   <= 1'b0;
      lsu_fault  <= 1'b0;
      lsu_rdata  <= 64'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 64'd0;
      dmem_wdata <= 64'd0;
      dmem_wstrb <= 8'd0;
    end else begin
      lsu_done  <= 1'b0;
      lsu_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
`ifdef LSU_MISALIGN_TRAP_EN
            if (misal) begin
              state     <= DONE;
              lsu_done  <= 1'b1;
              lsu_fault <= 1'b1;
            end else begin
`endif
              state      <= REQ;
              cnt        <= '0;
              is_load    <= ex_load;
              f3         <= ex_funct3;
              off        <= off_al;
              dmem_req   <= 1'b1;
              dmem_we    <= ~ex_load;
              dmem_addr  <= {ex_addr[63:3], 3'b000};
              dmem_wdata <= ex_load ? 64'd0 : st_wdata;
              dmem_wstrb <= ex_load ? 8'd0 : st_strb;
`ifdef LSU_MISALIGN_TRAP_EN
            end
`endif
          end
        end
        REQ: begin
          // Completion wins over timeout when both land in the same cycle
          if (dmem_gnt & dmem_rvalid) begin
            state    <= DONE;
            dmem_req <= 1'b0;
            lsu_done <= 1'b1;
            if (is_load) lsu_rdata <= ld_ext;
          end else if (tmo) begin
            state     <= DONE;
            dmem_req  <= 1'b0;
            lsu_done  <= 1'b1;
            lsu_fault <= 1'b1;
            lsu_rdata <= 64'd0;
          end else if (dmem_gnt) begin
            state    <= WAIT;
            dmem_req <= 1'b0;
            cnt      <= cnt + CW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            state    <= DONE;
            lsu_done <= 1'b1;
            if (is_load) lsu_rdata <= ld_ext;
          end else if (tmo) begin
            state     <= DONE;
            lsu_done  <= 1'b1;
            lsu_fault <= 1'b1;
            lsu_rdata <= 64'd0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
